// File: rtl/scene_loader_if.sv
// Byte-stream and flash-write bundle for scene_loader.
// slave = loader side, master = host/stream side.
interface scene_loader_if #(
  parameter int unsigned OBJ_WIDTH     = 20,
  parameter int unsigned OBJ_IDX_WIDTH = 4
);
  logic                     byte_valid;
  logic [7:0]               byte_data;
  logic                     byte_ready;
  logic                     flash_obj_wen;
  logic [OBJ_IDX_WIDTH-1:0] flash_obj_idx;
  logic [OBJ_WIDTH-1:0]     flash_obj_data;
  logic [OBJ_IDX_WIDTH-1:0] num_objs;
  logic                     busy;
  logic                     done;
  logic                     err;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, flash_obj_wen, flash_obj_idx, flash_obj_data,
           num_objs, busy, done, err
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, flash_obj_wen, flash_obj_idx, flash_obj_data,
           num_objs, busy, done, err
  );
endinterface

// File: rtl/scene_loader.sv
// Frames a 0xA5/count/objects byte stream into one flash write per object, then publishes num_objs.
// Optional trailing XOR checksum byte when SCENE_LOADER_CHECKSUM_EN is defined.
module scene_loader #(
  parameter int unsigned OBJ_WIDTH      = 20,
  parameter int unsigned OBJ_IDX_WIDTH  = 4,
  parameter int unsigned NUM_OBJS_INIT  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic           clk,
  input  logic           rst,
  scene_loader_if.slave  bus
);

  localparam int unsigned BYTES  = (OBJ_WIDTH + 7) / 8;
  localparam int unsigned ASM_W  = BYTES * 8;
  localparam int unsigned BCNT_W = $clog2(BYTES + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned MAX_N  = (OBJ_IDX_WIDTH >= 8) ? 255 : ((1 << OBJ_IDX_WIDTH) - 1);
  localparam logic [7:0]  SYNC   = 8'hA5;

`ifdef SCENE_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_OBJ, S_WRITE, S_COMMIT, S_CHECK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_OBJ, S_WRITE, S_COMMIT} state_t;
`endif

  state_t                   state_q, state_d;
  logic [OBJ_IDX_WIDTH-1:0] n_q, n_d;
  logic [OBJ_IDX_WIDTH-1:0] obj_cnt_q, obj_cnt_d;
  logic [BCNT_W-1:0]        byte_cnt_q, byte_cnt_d;
  logic [ASM_W-1:0]         asm_q, asm_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
`ifdef SCENE_LOADER_CHECKSUM_EN
  logic [7:0]               csum_q, csum_d;
`endif

  logic                     ready_q, ready_d;
  logic                     wen_q, wen_d;
  logic [OBJ_IDX_WIDTH-1:0] idx_q, idx_d;
  logic [OBJ_WIDTH-1:0]     data_q, data_d;
  logic [OBJ_IDX_WIDTH-1:0] num_q, num_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic accept;
  assign accept = bus.byte_valid & ready_q;

  // Next-state and next-output logic; every output is registered from these *_d values.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    obj_cnt_d  = obj_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    tmo_d      = tmo_q;
`ifdef SCENE_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    wen_d      = 1'b0;
    idx_d      = idx_q;
    data_d     = data_q;
    num_d      = num_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (accept && bus.byte_data == SYNC) state_d = S_COUNT;
      end

      S_COUNT: begin
        if (accept) begin
          if (bus.byte_data == 8'h00 || 32'(bus.byte_data) > MAX_N) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            n_d        = OBJ_IDX_WIDTH'(bus.byte_data);
            obj_cnt_d  = '0;
            byte_cnt_d = '0;
`ifdef SCENE_LOADER_CHECKSUM_EN
            csum_d     = bus.byte_data;
`endif
            state_d    = S_OBJ;
          end
        end
      end

      S_OBJ: begin
        if (accept) begin
          for (int unsigned b = 0; b < BYTES; b++) begin
            if (BCNT_W'(b) == byte_cnt_q) asm_d[8*b +: 8] = bus.byte_data;
          end
`ifdef SCENE_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.byte_data;
`endif
          if (byte_cnt_q == BCNT_W'(BYTES - 1)) begin
            wen_d   = 1'b1;
            idx_d   = obj_cnt_q;
            data_d  = asm_d[OBJ_WIDTH-1:0];
            state_d = S_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
          end
        end
      end

      S_WRITE: begin
        obj_cnt_d  = obj_cnt_q + OBJ_IDX_WIDTH'(1);
        byte_cnt_d = '0;
        if (obj_cnt_q == n_q - OBJ_IDX_WIDTH'(1)) begin
`ifdef SCENE_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_COMMIT;
          num_d   = n_q;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = S_OBJ;
        end
      end

`ifdef SCENE_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (bus.byte_data == csum_q) begin
            state_d = S_COMMIT;
            num_d   = n_q;
            done_d  = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif

      S_COMMIT: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Inactivity watchdog while a frame is open; any accepted byte restarts it.
    if (state_q == S_COUNT || state_q == S_OBJ
`ifdef SCENE_LOADER_CHECKSUM_EN
        || state_q == S_CHECK
`endif
       ) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    busy_d  = (state_d != S_IDLE);
    ready_d = !(state_d == S_WRITE || state_d == S_COMMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      obj_cnt_q  <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      tmo_q      <= '0;
`ifdef SCENE_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
      ready_q    <= 1'b1;
      wen_q      <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      num_q      <= OBJ_IDX_WIDTH'(NUM_OBJS_INIT);
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      obj_cnt_q  <= obj_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      tmo_q      <= tmo_d;
`ifdef SCENE_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
      ready_q    <= ready_d;
      wen_q      <= wen_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      num_q      <= num_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.byte_ready     = ready_q;
  assign bus.flash_obj_wen  = wen_q;
  assign bus.flash_obj_idx  = idx_q;
  assign bus.flash_obj_data = data_q;
  assign bus.num_objs       = num_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_scene_loader.sv
// Scoreboard bench for scene_loader: stimulus pushes expected writes/events, a negedge monitor pops and compares.
// Follows SCENE_LOADER_CHECKSUM_EN the same way the design does.
module tb_scene_loader;

  localparam int unsigned OBJ_W  = 20;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned INIT_N = 1;
  localparam int unsigned TMO    = 40;
  localparam int unsigned NB     = 3;

  typedef logic [7:0] byte_q_t[$];
  typedef struct { logic [IDX_W-1:0] idx; logic [OBJ_W-1:0] data; } wr_t;
  typedef struct { bit is_err; logic [IDX_W-1:0] num; } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scene_loader_if #(.OBJ_WIDTH(OBJ_W), .OBJ_IDX_WIDTH(IDX_W)) bus ();

  scene_loader #(
    .OBJ_WIDTH(OBJ_W), .OBJ_IDX_WIDTH(IDX_W),
    .NUM_OBJS_INIT(INIT_N), .TIMEOUT_CYCLES(TMO)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  wr_t exp_wr[$];
  ev_t exp_ev[$];
  int  model_num = INIT_N;
`ifdef SCENE_LOADER_CHECKSUM_EN
  logic [7:0] cs_flip = 8'h00;
`endif

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT writes or finishes a frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.flash_obj_wen) begin
        check("ready_low_in_write", 32'(bus.byte_ready), 32'd0);
        if (exp_wr.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_wen: idx=%0d data=0x%0h, required no write", bus.flash_obj_idx, bus.flash_obj_data);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wen_idx", 32'(bus.flash_obj_idx), 32'(w.idx));
          check("wen_data", 32'(bus.flash_obj_data), 32'(w.data));
        end
      end
      if (bus.done || bus.err) begin
        check("done_err_exclusive", 32'(bus.done & bus.err), 32'd0);
        if (exp_ev.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_event: done=%0b err=%0b, required none", bus.done, bus.err);
        end else begin
          ev_t e;
          e = exp_ev.pop_front();
          check("event_is_err", 32'(bus.err), 32'(e.is_err));
          check("event_num_objs", 32'(bus.num_objs), 32'(e.num));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waitc = 0;
    repeat (gap) begin @(negedge clk); bus.byte_valid = 1'b0; end
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && waitc < 20) begin @(negedge clk); waitc++; end
    if (!bus.byte_ready) begin
      n_checks++; n_fail++;
      $display("FAIL byte_ready_wait: still low after %0d cycles, required high", waitc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); bus.byte_valid = 1'b0; end
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_wr.size() != 0 || exp_ev.size() != 0) && c < 100) begin @(negedge clk); c++; end
    check("scoreboard_drained", 32'(exp_wr.size() + exp_ev.size()), 32'd0);
  endtask

  // Reference: object k is bytes 3k..3k+2 read little-endian, truncated to OBJ_W bits.
  task automatic send_frame(input byte_q_t ob, input int n, input int maxgap);
    wr_t w;
    ev_t e;
    logic [7:0] cs;
    for (int k = 0; k < n; k++) begin
      int unsigned v;
      v = 32'(ob[NB*k]) + (32'(ob[NB*k+1]) << 8) + (32'(ob[NB*k+2]) << 16);
      w.idx  = IDX_W'(k);
      w.data = OBJ_W'(v % (1 << OBJ_W));
      exp_wr.push_back(w);
    end
`ifdef SCENE_LOADER_CHECKSUM_EN
    if (cs_flip != 8'h00) begin
      e.is_err = 1'b1; e.num = IDX_W'(model_num);
    end else begin
      e.is_err = 1'b0; e.num = IDX_W'(n); model_num = n;
    end
`else
    e.is_err = 1'b0; e.num = IDX_W'(n); model_num = n;
`endif
    exp_ev.push_back(e);
    send_byte(8'hA5, $urandom_range(0, maxgap));
    send_byte(8'(n), $urandom_range(0, maxgap));
    cs = 8'(n);
    for (int i = 0; i < n * NB; i++) begin
      send_byte(ob[i], $urandom_range(0, maxgap));
      cs = cs ^ ob[i];
    end
`ifdef SCENE_LOADER_CHECKSUM_EN
    send_byte(cs ^ cs_flip, $urandom_range(0, maxgap));
`else
    if (cs == 8'h00) cs = 8'h00;
`endif
    idle(1);
  endtask

  task automatic send_bad_count(input logic [7:0] n);
    ev_t e;
    e.is_err = 1'b1; e.num = IDX_W'(model_num);
    exp_ev.push_back(e);
    send_byte(8'hA5, 0);
    send_byte(n, 0);
    idle(1);
  endtask

  task automatic check_reset_outputs();
    check("rst_byte_ready", 32'(bus.byte_ready), 32'd1);
    check("rst_wen", 32'(bus.flash_obj_wen), 32'd0);
    check("rst_idx", 32'(bus.flash_obj_idx), 32'd0);
    check("rst_data", 32'(bus.flash_obj_data), 32'd0);
    check("rst_num_objs", 32'(bus.num_objs), 32'(INIT_N));
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
  endtask

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  initial begin
    byte_q_t ob;
    int edges;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    // Worked example: 0x32211 then 0x65544, num_objs -> 2.
    ob = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_frame(ob, 2, 0);
    drain();
    check("example_num_objs", 32'(bus.num_objs), 32'd2);

    // Zero and out-of-range counts abort without writes.
    send_bad_count(8'h00);
    send_bad_count(8'h10);
    drain();
    check("bad_count_num_objs", 32'(bus.num_objs), 32'd2);

    // Continuous byte_valid across WRITE cycles, and 0xA5 as object data.
    send_frame(rand_bytes(4 * NB), 4, 0);
    ob = {8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'hA5};
    send_frame(ob, 2, 0);
    drain();

    // Stall after one object byte: err exactly TMO cycles after the last accepted byte.
    begin
      ev_t e;
      e.is_err = 1'b1; e.num = IDX_W'(model_num);
      exp_ev.push_back(e);
    end
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h7E, 0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    edges = 0;
    while (!bus.err && edges < 2 * TMO) begin @(negedge clk); edges++; end
    check("timeout_cycles", 32'(edges), 32'(TMO));
    check("timeout_busy", 32'(bus.busy), 32'd0);
    check("timeout_num_objs", 32'(bus.num_objs), 32'(model_num));
    drain();

    // Reset after the first object of an N=3 frame.
    begin
      wr_t w;
      w.idx = '0; w.data = OBJ_W'(32'h0C0B0A);
      exp_wr.push_back(w);
    end
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h0A, 0);
    send_byte(8'h0B, 0);
    send_byte(8'h0C, 0);
    idle(3);
    drain();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    model_num = INIT_N;
    send_frame(rand_bytes(3 * NB), 3, 1);
    drain();
    check("post_reset_num_objs", 32'(bus.num_objs), 32'd3);

`ifdef SCENE_LOADER_CHECKSUM_EN
    cs_flip = 8'h00;
    send_frame(rand_bytes(2 * NB), 2, 1);
    cs_flip = 8'h10;
    send_frame(rand_bytes(3 * NB), 3, 1);
    cs_flip = 8'h00;
    drain();
    check("cs_bad_num_objs", 32'(bus.num_objs), 32'd2);
`endif

    // Randomised frames with line noise in between.
    for (int it = 0; it < 12; it++) begin
      int n;
      int junk;
      junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) begin
        logic [7:0] g;
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, $urandom_range(0, 2));
      end
      if ($urandom_range(0, 5) == 0) begin
        send_bad_count(8'($urandom_range(16, 255)));
      end else begin
        n = $urandom_range(1, 6);
`ifdef SCENE_LOADER_CHECKSUM_EN
        cs_flip = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
`endif
        send_frame(rand_bytes(n * NB), n, 3);
      end
    end
    idle(5);
    drain();
    check("final_num_objs", 32'(bus.num_objs), 32'(model_num));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
